matrix_inverse_calculator: RTL and testbench

Computes the inverse of a 3x3 signed-integer matrix as signed fixed-point values, using the adjugate divided by the determinant. It is a standalone compute block in the linear-algebra datapath. The block has a start/done handshake and reports the determinant and a singular flag. Divisions run one element at a time through a shared sequential divider.

---
 rtl/matrix_inv_pkg.sv | 26 ++
 rtl/mat_seq_divider.sv | 66 ++++++
 rtl/matrix_inverse_calculator.sv | 166 ++++++++++++++++
 tb/tb_matrix_inverse_calculator.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/matrix_inv_pkg.sv
// Shared widths, FSM encoding and index helper for the 3x3 matrix inverse block.
package matrix_inv_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_FRAC_W = 8;
  localparam int unsigned DEF_OUT_W  = 24;
  localparam int unsigned DEF_ADJ_W  = 2 * DEF_DATA_W + 1;
  localparam int unsigned DEF_DET_W  = 3 * DEF_DATA_W + 2;
  localparam int unsigned DEF_Q_W    = DEF_ADJ_W + DEF_FRAC_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COF,
    S_DET,
    S_DIV,
    S_WR,
    S_FIN
  } state_t;

  // Row-major element index of (r,c).
  function automatic int idx(input int r, input int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/mat_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; quotient valid Q_W cycles after start.
module mat_seq_divider #(
  parameter int unsigned Q_W   = 25,
  parameter int unsigned DET_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [Q_W-1:0]   dividend,
  input  logic [DET_W-1:0] divisor,
  output logic             busy,
  output logic             valid,
  output logic [Q_W-1:0]   quotient
);

  localparam int unsigned CNT_W = $clog2(Q_W + 1);

  logic [DET_W-1:0] rem_q;
  logic [DET_W-1:0] dsr_q;
  logic [DET_W-1:0] src_rem;
  logic [DET_W-1:0] src_dsr;
  logic [DET_W-1:0] rem_n;
  logic [Q_W-1:0]   src_dvd;
  logic [DET_W:0]   trial;
  logic             ge;
  logic [CNT_W-1:0] cnt_q;

  // The first step is folded into the load cycle, so Q_W-1 further steps remain.
  always_comb begin
    src_rem = start ? '0 : rem_q;
    src_dvd = start ? dividend : quotient;
    src_dsr = start ? divisor : dsr_q;
    trial   = {src_rem, src_dvd[Q_W-1]};
    ge      = (trial >= {1'b0, src_dsr});
    rem_n   = ge ? DET_W'(trial - {1'b0, src_dsr}) : trial[DET_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      dsr_q    <= '0;
      quotient <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
    end else if (start) begin
      rem_q    <= rem_n;
      dsr_q    <= divisor;
      quotient <= {src_dvd[Q_W-2:0], ge};
      cnt_q    <= CNT_W'(Q_W - 1);
      busy     <= 1'b1;
      valid    <= 1'b0;
    end else if (busy) begin
      rem_q    <= rem_n;
      quotient <= {src_dvd[Q_W-2:0], ge};
      cnt_q    <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy  <= 1'b0;
        valid <= 1'b1;
      end
    end else begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/matrix_inverse_calculator.sv
// 3x3 signed-integer matrix inverse via adjugate / determinant, fixed-point output with saturation.
module matrix_inverse_calculator
  import matrix_inv_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned FRAC_W = DEF_FRAC_W,
  parameter int unsigned OUT_W  = DEF_OUT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [9*DATA_W-1:0]   a_in,
  output logic                  busy,
  output logic                  done,
  output logic                  singular,
  output logic [3*DATA_W+1:0]   det_out,
  output logic [9*OUT_W-1:0]    inv_out
);

  localparam int unsigned ADJ_W = 2 * DATA_W + 1;
  localparam int unsigned DET_W = 3 * DATA_W + 2;
  localparam int unsigned Q_W   = ADJ_W + FRAC_W;
  localparam int unsigned SAT_W = Q_W + OUT_W + 1;
  localparam logic signed [SAT_W-1:0] SAT_MAX = SAT_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [SAT_W-1:0] SAT_MIN = -SAT_MAX - SAT_W'(1);

  state_t state, next_state;

  logic signed [DATA_W-1:0] a_q   [9];
  logic signed [ADJ_W-1:0]  cof_c [9];
  logic signed [ADJ_W-1:0]  cof_q [9];
  logic signed [DET_W-1:0]  det_c;
  logic signed [DET_W-1:0]  det_sel;
  logic signed [ADJ_W-1:0]  adj_sel;
  logic [ADJ_W-1:0]         adj_mag;
  logic [DET_W-1:0]         det_mag;
  logic [3:0]               k;
  logic [3:0]               div_k;
  logic                     sign_q;
  logic                     div_start_c;
  logic                     div_busy;
  logic                     div_valid;
  logic [Q_W-1:0]           quotient;
  logic signed [SAT_W-1:0]  q_mag;
  logic signed [SAT_W-1:0]  q_val;
  logic [OUT_W-1:0]         q_sat;

  // Cyclic-index cofactor form carries the (-1)^(r+c) sign implicitly for 3x3.
  always_comb begin
    cof_c = '{default: '0};
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        cof_c[idx(r, c)] =
            ADJ_W'(a_q[idx((r + 1) % 3, (c + 1) % 3)]) * ADJ_W'(a_q[idx((r + 2) % 3, (c + 2) % 3)])
          - ADJ_W'(a_q[idx((r + 1) % 3, (c + 2) % 3)]) * ADJ_W'(a_q[idx((r + 2) % 3, (c + 1) % 3)]);
      end
    end
  end

  always_comb begin
    det_c = DET_W'(a_q[0]) * DET_W'(cof_q[0])
          + DET_W'(a_q[1]) * DET_W'(cof_q[1])
          + DET_W'(a_q[2]) * DET_W'(cof_q[2]);
  end

  // Operand select: element 0 is launched from DET, the rest from the preceding WR.
  always_comb begin
    div_k   = (state == S_WR) ? k + 4'd1 : 4'd0;
    adj_sel = cof_q[idx(int'(div_k) % 3, int'(div_k) / 3)];
    det_sel = (state == S_DET) ? det_c : signed'(det_out);
    adj_mag = adj_sel[ADJ_W-1] ? ADJ_W'(-adj_sel) : ADJ_W'(adj_sel);
    det_mag = det_sel[DET_W-1] ? DET_W'(-det_sel) : DET_W'(det_sel);
  end

  always_comb begin
    q_mag = SAT_W'(quotient);
    q_val = sign_q ? -q_mag : q_mag;
    if (q_val > SAT_MAX)      q_sat = OUT_W'(SAT_MAX);
    else if (q_val < SAT_MIN) q_sat = OUT_W'(SAT_MIN);
    else                      q_sat = OUT_W'(q_val);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (start) next_state = S_LOAD;
      S_LOAD:  next_state = S_COF;
      S_COF:   next_state = S_DET;
      S_DET:   next_state = (det_c == '0) ? S_FIN : S_DIV;
      S_DIV:   if (div_valid) next_state = S_WR;
      S_WR:    next_state = (k == 4'd8) ? S_FIN : S_DIV;
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    div_start_c = 1'b0;
    if (!div_busy) begin
      if (state == S_DET && det_c != '0) div_start_c = 1'b1;
      if (state == S_WR && k != 4'd8)    div_start_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      singular <= 1'b0;
      det_out  <= '0;
      inv_out  <= '0;
      k        <= '0;
      sign_q   <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        a_q[i]   <= '0;
        cof_q[i] <= '0;
      end
    end else begin
      busy <= (next_state != S_IDLE);
      done <= (next_state == S_FIN);
      if (state == S_IDLE && start) begin
        for (int i = 0; i < 9; i++) a_q[i] <= a_in[i*DATA_W +: DATA_W];
      end
      if (div_start_c) sign_q <= adj_sel[ADJ_W-1] ^ det_sel[DET_W-1];
      case (state)
        S_LOAD: singular <= 1'b0;
        S_COF: begin
          for (int i = 0; i < 9; i++) cof_q[i] <= cof_c[i];
        end
        S_DET: begin
          det_out <= det_c;
          k       <= '0;
          if (det_c == '0) begin
            singular <= 1'b1;
            inv_out  <= '0;
          end
        end
        S_WR: begin
          inv_out[int'(k)*OUT_W +: OUT_W] <= q_sat;
          k <= k + 4'd1;
        end
        default: ;
      endcase
    end
  end

  mat_seq_divider #(
    .Q_W   (Q_W),
    .DET_W (DET_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start_c),
    .dividend ({adj_mag, FRAC_W'(0)}),
    .divisor  (det_mag),
    .busy     (div_busy),
    .valid    (div_valid),
    .quotient (quotient)
  );

endmodule

// File: tb/tb_matrix_inverse_calculator.sv
// Directed bench for matrix_inverse_calculator: default widths plus an OUT_W=12 saturation instance.
module tb_matrix_inverse_calculator;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          start12 = 1'b0;
  logic [71:0]   a_in = '0;
  logic [71:0]   a_in12 = '0;
  logic          busy, done, singular;
  logic          busy12, done12, singular12;
  logic [25:0]   det_out, det12;
  logic [215:0]  inv_out;
  logic [107:0]  inv12;

  int compared = 0;
  int mismatched = 0;
  int exp_inv [9];

  always #5 clk = ~clk;

  matrix_inverse_calculator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in),
    .busy(busy), .done(done), .singular(singular), .det_out(det_out), .inv_out(inv_out)
  );

  matrix_inverse_calculator #(.OUT_W(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .start(start12), .a_in(a_in12),
    .busy(busy12), .done(done12), .singular(singular12), .det_out(det12), .inv_out(inv12)
  );

  function automatic logic [71:0] mk(input int e0, input int e1, input int e2,
                                     input int e3, input int e4, input int e5,
                                     input int e6, input int e7, input int e8);
    logic [71:0] m;
    m = {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    return m;
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start, wait for done with a bounded budget, and check latency and pulse shape.
  task automatic run_op(input int sel, input logic [71:0] m, input int exp_lat,
                        input int repulse_at, input string tag);
    int cyc;
    @(negedge clk);
    if (sel == 0) begin a_in = m; start = 1'b1; end
    else begin a_in12 = m; start12 = 1'b1; end
    @(negedge clk);
    start = 1'b0;
    start12 = 1'b0;
    cyc = 1;
    check({tag, "_busy_early"}, 64'((sel == 0) ? busy : busy12), 64'd1);
    while (((sel == 0) ? done : done12) !== 1'b1 && cyc < exp_lat + 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == repulse_at) begin
        a_in = mk(2, 0, 0, 0, 4, 0, 0, 0, 8);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_done"}, 64'((sel == 0) ? done : done12), 64'd1);
    @(negedge clk);
    check({tag, "_done_single"}, 64'((sel == 0) ? done : done12), 64'd0);
    check({tag, "_busy_after"}, 64'((sel == 0) ? busy : busy12), 64'd0);
  endtask

  task automatic check_result(input int sel, input string tag,
                              input logic signed [63:0] exp_det, input int exp_sing);
    logic signed [25:0] d;
    logic signed [23:0] e24;
    logic signed [11:0] e12;
    logic signed [63:0] v;
    d = (sel == 0) ? det_out : det12;
    check({tag, "_det"}, 64'(d), exp_det);
    check({tag, "_singular"}, 64'((sel == 0) ? singular : singular12), 64'(exp_sing));
    for (int i = 0; i < 9; i++) begin
      if (sel == 0) begin
        e24 = inv_out[i*24 +: 24];
        v = 64'(e24);
      end else begin
        e12 = inv12[i*12 +: 12];
        v = 64'(e12);
      end
      check($sformatf("%s_inv%0d", tag, i), v, 64'(exp_inv[i]));
    end
  endtask

  initial begin
    int pulses;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_singular", 64'(singular), 64'd0);
    check("rst_det", 64'(det_out), 64'd0);
    check("rst_inv_nz", 64'(inv_out != '0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, mk(1, 0, 0, 0, 1, 0, 0, 0, 1), 238, 0, "ident");
    exp_inv = '{256, 0, 0, 0, 256, 0, 0, 0, 256};
    check_result(0, "ident", 64'sd1, 0);

    run_op(0, mk(2, 0, 0, 0, 4, 0, 0, 0, 8), 238, 0, "diag248");
    exp_inv = '{128, 0, 0, 0, 64, 0, 0, 0, 32};
    check_result(0, "diag248", 64'sd64, 0);

    run_op(0, mk(2, 0, 0, 0, -1, 0, 0, 0, 3), 238, 0, "negdet");
    exp_inv = '{128, 0, 0, 0, -256, 0, 0, 0, 85};
    check_result(0, "negdet", -64'sd6, 0);

    run_op(0, mk(1, 2, 3, 4, 5, 6, 7, 8, 9), 4, 0, "sing");
    exp_inv = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_result(0, "sing", 64'sd0, 1);

    run_op(1, mk(1, 100, 0, 0, 1, 0, 0, 0, 1), 238, 0, "sat12");
    exp_inv = '{256, -2048, 0, 0, 256, 0, 0, 0, 256};
    check_result(1, "sat12", 64'sd1, 0);

    // A second start mid-computation must be ignored.
    run_op(0, mk(1, 0, 0, 0, 1, 0, 0, 0, 1), 238, 100, "repulse");
    exp_inv = '{256, 0, 0, 0, 256, 0, 0, 0, 256};
    check_result(0, "repulse", 64'sd1, 0);

    // Reset during DIV clears everything and no done pulse follows.
    @(negedge clk);
    a_in = mk(1, 0, 0, 0, 1, 0, 0, 0, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    check("mid_busy_before_rst", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_singular", 64'(singular), 64'd0);
    check("midrst_det", 64'(det_out), 64'd0);
    check("midrst_inv_nz", 64'(inv_out != '0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (300) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    check("midrst_no_activity", 64'(pulses), 64'd0);

    run_op(0, mk(2, 0, 0, 0, 4, 0, 0, 0, 8), 238, 0, "fresh");
    exp_inv = '{128, 0, 0, 0, 64, 0, 0, 0, 32};
    check_result(0, "fresh", 64'sd64, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
